// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle main controller.
//   - FSM state codes (FETCH, DECODE, EXEC, MEM, WB, HALT)
//   - opcode class and sub-op constants
//   - ALU-op and jump-select encodings
//   - ctrl_t: decoded control bundle latched for EXEC/MEM/WB
package mc_ctrl_pkg;

    // FSM state encoding (kept as plain constants for legacy tools)
    typedef logic [2:0] state_t;
    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;

    // Opcode class field
    localparam logic [2:0] SR  = 3'b000;
    localparam logic [2:0] LS  = 3'b001;
    localparam logic [2:0] SI  = 3'b010;
    localparam logic [2:0] SI2 = 3'b011;
    localparam logic [2:0] DR  = 3'b100;
    localparam logic [2:0] GR  = 3'b101;
    localparam logic [2:0] JR  = 3'b110;
    localparam logic [2:0] J   = 3'b111;

    // Sub-op field values with special meaning
    localparam logic [2:0] LWR = 3'b000;
    localparam logic [2:0] STR = 3'b001;
    localparam logic [2:0] BRC = 3'b101;

    // ALU operation class
    localparam logic [1:0] ALU_R = 2'b00;
    localparam logic [1:0] ALU_I = 2'b01;
    localparam logic [1:0] ALU_D = 2'b10;
    localparam logic [1:0] ALU_B = 2'b11;

    // Jump select
    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_DIR  = 2'b01;
    localparam logic [1:0] JMP_REG  = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       branch;
        logic       mem_write;
        logic       mem_to_reg;
        logic [1:0] jump;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode -> ctrl_t decoder.
//   op   : opcode, class = op[OP_W-1:OP_W-3], sub = op[OP_W-4:OP_W-6]
//   ctrl : decoded control bundle; every field is defined for every opcode
module mc_decode
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    output ctrl_t           ctrl
);

    logic [2:0] cls;
    logic [2:0] sub;

    assign cls = op[OP_W-1 -: 3];
    assign sub = op[OP_W-4 -: 3];

    always_comb begin
        ctrl = '0;
        case (cls)
            SR: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_R;
            end
            LS: begin
                if (sub == LWR) begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end else if (sub == STR) begin
                    ctrl.mem_write = 1'b1;
                end else begin
                    // Unused LS sub-ops behave as a plain register op
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALU_R;
                end
            end
            SI, SI2: begin
                if (sub == BRC) begin
                    ctrl.branch = 1'b1;
                    ctrl.alu_op = ALU_B;
                end else begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.alu_op    = ALU_I;
                end
            end
            DR: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_D;
            end
            GR: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_I;
            end
            JR: begin
                ctrl.jump   = JMP_REG;
                ctrl.alu_op = ALU_B;
            end
            J: begin
                ctrl.jump   = JMP_DIR;
                ctrl.alu_op = ALU_B;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle main controller, FETCH/DECODE/EXEC/MEM/WB sequencing.
//   clk, reset         : clock, synchronous active-high reset
//   op                 : opcode from IR, sampled in DECODE
//   halt_req           : stop at the next instruction boundary
//   imem_ack/dmem_ack  : memory handshake acknowledges
//   imem_req/dmem_req/dmem_we : memory requests
//   ir_we/pc_we/reg_write     : one-cycle write strobes
//   alu_src/branch/mem_to_reg/jump/alu_op : datapath selects (EXEC/MEM/WB)
//   halted, mem_err    : HALT state, sticky dmem timeout
//   inst_count         : retired-instruction counter (wraps)
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic             halt_req,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_write,
    output logic             alu_src,
    output logic             branch,
    output logic             mem_to_reg,
    output logic [1:0]       jump,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] inst_count
);

    localparam int WT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WT_W-1:0] WT_LAST = WT_W'(MEM_TIMEOUT - 1);

    state_t          state, state_nxt;
    ctrl_t           dec_ctrl, ctrl_q;
    logic [WT_W-1:0] wait_cnt;
    logic            retire, timeout, wait_clr, wait_inc, lvl_en;

    mc_decode #(.OP_W(OP_W)) u_decode (
        .op   (op),
        .ctrl (dec_ctrl)
    );

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        timeout   = 1'b0;
        wait_clr  = 1'b0;
        wait_inc  = 1'b0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_write = 1'b0;
        halted    = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we     = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: state_nxt = EXEC;
            EXEC: begin
                if (ctrl_q.branch || (ctrl_q.jump != JMP_NONE)) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end else if (ctrl_q.mem_write || ctrl_q.mem_to_reg) begin
                    wait_clr  = 1'b1;
                    state_nxt = MEM;
                end else begin
                    state_nxt = WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = ctrl_q.mem_write;
                if (dmem_ack) begin
                    if (ctrl_q.mem_write) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        state_nxt = WB;
                    end
                end else if (wait_cnt == WT_LAST) begin
                    // This was the last permitted wait cycle: abandon the access
                    timeout   = 1'b1;
                    state_nxt = HALT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            WB: begin
                reg_write = ctrl_q.reg_write;
                pc_we     = 1'b1;
                retire    = 1'b1;
            end
            HALT: begin
                halted = 1'b1;
                if (!mem_err && !halt_req) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
        // Instruction boundary: halt_req is only honoured here
        if (retire) state_nxt = halt_req ? HALT : FETCH;
    end

    // Datapath selects are only meaningful while an instruction executes
    assign lvl_en     = (state == EXEC) || (state == MEM) || (state == WB);
    assign alu_src    = lvl_en & ctrl_q.alu_src;
    assign branch     = lvl_en & ctrl_q.branch;
    assign mem_to_reg = lvl_en & ctrl_q.mem_to_reg;
    assign jump       = lvl_en ? ctrl_q.jump   : 2'b00;
    assign alu_op     = lvl_en ? ctrl_q.alu_op : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            ctrl_q     <= '0;
            wait_cnt   <= '0;
            mem_err    <= 1'b0;
            inst_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == DECODE) ctrl_q <= dec_ctrl;
            if (wait_clr)      wait_cnt <= '0;
            else if (wait_inc) wait_cnt <= wait_cnt + WT_W'(1);
            if (timeout) mem_err <= 1'b1;
            if (retire)  inst_count <= inst_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl. Each driven cycle pushes the
// expected output vector and retired count; the negedge monitor pops and
// compares against the DUT.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  op = 6'b0;
    logic        halt_req = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_write;
    logic        alu_src, branch, mem_to_reg, halted, mem_err;
    logic [1:0]  jump, alu_op;
    logic [15:0] inst_count;

    mc_ctrl #(.OP_W(6), .CNT_W(16), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .op(op), .halt_req(halt_req),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .pc_we(pc_we), .reg_write(reg_write),
        .alu_src(alu_src), .branch(branch), .mem_to_reg(mem_to_reg),
        .jump(jump), .alu_op(alu_op), .halted(halted), .mem_err(mem_err),
        .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    // Output vector bit masks
    localparam logic [14:0] IMR  = 15'h4000;
    localparam logic [14:0] DMR  = 15'h2000;
    localparam logic [14:0] DWE  = 15'h1000;
    localparam logic [14:0] IRW  = 15'h0800;
    localparam logic [14:0] PCW  = 15'h0400;
    localparam logic [14:0] RW   = 15'h0200;
    localparam logic [14:0] AS   = 15'h0100;
    localparam logic [14:0] BR   = 15'h0080;
    localparam logic [14:0] M2R  = 15'h0040;
    localparam logic [14:0] JD   = 15'h0010;
    localparam logic [14:0] A01  = 15'h0004;
    localparam logic [14:0] A10  = 15'h0008;
    localparam logic [14:0] A11  = 15'h000C;
    localparam logic [14:0] HLT  = 15'h0002;
    localparam logic [14:0] MERR = 15'h0001;

    logic [14:0] obs;
    assign obs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_write,
                  alu_src, branch, mem_to_reg, jump, alu_op, halted, mem_err};

    typedef struct {
        string       tag;
        logic [14:0] outs;
        int          cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.tag, 32'(obs), 32'(e.outs));
            check({e.tag, "_cnt"}, 32'(inst_count), 32'(e.cnt));
        end
    end

    // One clock cycle: drive inputs just after the edge, record expectation
    task automatic step(input string tag, input bit ia, input bit da, input bit hr,
                        input bit rs, input logic [14:0] e, input int cnt);
        @(posedge clk);
        #1;
        imem_ack = ia;
        dmem_ack = da;
        halt_req = hr;
        reset    = rs;
        q.push_back('{tag, e, cnt});
    endtask

    // Fetch with ack in the first FETCH cycle, then DECODE
    task automatic fetch(input string tag, input logic [5:0] o, input int cnt);
        op = o;
        step({tag, "_f"}, 1, 0, 0, 0, IMR | IRW, cnt);
        step({tag, "_d"}, 0, 0, 0, 0, 15'h0, cnt);
    endtask

    initial begin
        repeat (2) @(posedge clk);

        // SI with imem_ack on the second FETCH cycle
        step("rst_state", 0, 0, 0, 0, IMR, 0);
        fetch("si", 6'b010000, 0);
        step("si_e",  0, 0, 0, 0, AS | A01, 0);
        step("si_wb", 0, 0, 0, 0, RW | PCW | AS | A01, 0);

        // LWR with ack on the third MEM cycle
        fetch("lwr", 6'b001000, 1);
        step("lwr_e",  0, 0, 0, 0, M2R, 1);
        step("lwr_m1", 0, 0, 0, 0, DMR | M2R, 1);
        step("lwr_m2", 0, 0, 0, 0, DMR | M2R, 1);
        step("lwr_m3", 0, 1, 0, 0, DMR | M2R, 1);
        step("lwr_wb", 0, 0, 0, 0, RW | PCW | M2R, 1);

        // STR with single-cycle access
        fetch("str", 6'b001001, 2);
        step("str_e",  0, 0, 0, 0, 15'h0, 2);
        step("str_m1", 0, 1, 0, 0, DMR | DWE | PCW, 2);

        // BRC, J, illegal LS
        fetch("brc", 6'b010101, 3);
        step("brc_e", 0, 0, 0, 0, BR | A11 | PCW, 3);
        fetch("j", 6'b111000, 4);
        step("j_e", 0, 0, 0, 0, JD | A11 | PCW, 4);
        fetch("ils", 6'b001110, 5);
        step("ils_e",  0, 0, 0, 0, 15'h0, 5);
        step("ils_wb", 0, 0, 0, 0, RW | PCW, 5);

        // DR with halt_req in WB, then resume
        fetch("dr", 6'b100000, 6);
        step("dr_e",   0, 0, 0, 0, A10, 6);
        step("dr_wb",  0, 0, 1, 0, RW | PCW | A10, 6);
        step("dr_h1",  0, 0, 1, 0, HLT, 7);
        step("dr_h2",  0, 0, 0, 0, HLT, 7);
        step("resume", 0, 0, 0, 0, IMR, 7);

        // Reset in the middle of a memory access
        fetch("mrst", 6'b001000, 7);
        step("mrst_e",  0, 0, 1, 0, M2R, 7);
        step("mrst_m1", 0, 0, 0, 1, DMR | M2R, 7);
        step("mrst_f",  0, 0, 0, 0, IMR, 0);

        // LWR timeout, halt_req toggling ignored, reset recovers
        fetch("to", 6'b001000, 0);
        step("to_e",  0, 0, 0, 0, M2R, 0);
        step("to_m1", 0, 0, 1, 0, DMR | M2R, 0);
        step("to_m2", 0, 0, 0, 0, DMR | M2R, 0);
        step("to_m3", 0, 0, 1, 0, DMR | M2R, 0);
        step("to_m4", 0, 0, 0, 0, DMR | M2R, 0);
        step("to_h1", 0, 0, 1, 0, HLT | MERR, 0);
        step("to_h2", 0, 0, 0, 0, HLT | MERR, 0);
        step("to_h3", 0, 0, 1, 0, HLT | MERR, 0);
        step("to_rs", 0, 0, 0, 1, HLT | MERR, 0);
        step("to_f",  0, 0, 0, 0, IMR, 0);

        @(negedge clk);
        #1;
        check("drain", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
